// File: rtl/ee357_alu_muldiv.sv
// Execute-stage ALU: combinational ops with zero latency, plus an iterative mul/div engine writing HI/LO.
// Mul/div takes WIDTH+1 busy cycles then a one-cycle done pulse; starts during busy are dropped (caller stalls on busy).
module ee357_alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] res,
   output logic             uov,
   output logic             sov,
   output logic             zero,
   output logic             cout,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   typedef struct packed {
      logic is_div;
      logic neg_q;   // negate product (mul) or quotient (div)
      logic neg_r;   // negate remainder
      logic dz;
   } ctl_t;

   // ---------------- combinational ALU ----------------
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             add_ovf;
   logic [SW-1:0]    shamt;

   always_comb begin
      is_sub  = (func == F_SUB) || (func == F_SLT) || (func == F_SLTU);
      b_eff   = is_sub ? ~opb : opb;
      {carry, sum} = {1'b0, opa} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      add_ovf = (opa[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      shamt   = opa[SW-1:0];
   end

   always_comb begin
      res  = '0;
      uov  = 1'b0;
      sov  = 1'b0;
      cout = 1'b0;
      case (func)
         F_ADD: begin
            res  = sum;
            cout = carry;
            uov  = carry;
            sov  = add_ovf;
         end
         F_SUB, F_SLT, F_SLTU: begin
            cout = carry;
            uov  = ~carry;
            sov  = add_ovf;
            if (func == F_SUB)
               res = sum;
            else if (func == F_SLT)
               res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            else
               res = {{(WIDTH-1){1'b0}}, ~carry};
         end
         F_AND:  res = opa & opb;
         F_OR:   res = opa | opb;
         F_XOR:  res = opa ^ opb;
         F_NOR:  res = ~(opa | opb);
         F_SLL:  res = opb << shamt;
         F_SRL:  res = opb >> shamt;
         F_SRA:  res = $unsigned($signed(opb) >>> shamt);
         F_MFHI: res = hi;
         F_MFLO: res = lo;
         default: res = '0;
      endcase
   end

   assign zero = (res == '0);

   // ---------------- mul/div engine ----------------
   state_t           state, state_nxt;
   ctl_t             ctl;
   logic [SW-1:0]    cnt;
   logic [WIDTH-1:0] opnd;     // multiplicand for mul, divisor for div
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic             is_md, is_signed, is_div_f, a_neg, b_neg, accept_md, accept_mt;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      is_md     = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
      is_signed = (func == F_MULT) || (func == F_DIV);
      is_div_f  = (func == F_DIV) || (func == F_DIVU);
      a_neg     = is_signed & opa[WIDTH-1];
      b_neg     = is_signed & opb[WIDTH-1];
      mag_a     = a_neg ? -opa : opa;
      mag_b     = b_neg ? -opb : opb;
      accept_md = start && (state == S_IDLE) && is_md;
      accept_mt = start && (state == S_IDLE) && ((func == F_MTHI) || (func == F_MTLO));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (accept_md)
               state_nxt = S_RUN;
         end
         S_RUN:   if (cnt == CNT_LAST) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One iteration: shift-add for mul, restoring subtract for div
   logic             m_c;
   logic [WIDTH-1:0] m_s;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] hi_step, lo_step;

   always_comb begin
      {m_c, m_s} = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : {WIDTH{1'b0}})};
      shifted    = {work_hi, work_lo[WIDTH-1]};
      ge         = shifted >= {1'b0, opnd};
      diff       = shifted[WIDTH-1:0] - opnd;
      if (ctl.is_div) begin
         hi_step = ge ? diff : shifted[WIDTH-1:0];
         lo_step = {work_lo[WIDTH-2:0], ge};
      end else begin
         hi_step = {m_c, m_s[WIDTH-1:1]};
         lo_step = {m_s[0], work_lo[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      prod_fix = ctl.neg_q ? -{work_hi, work_lo} : {work_hi, work_lo};
      if (!ctl.is_div) begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end else if (ctl.dz) begin
         fix_hi = a_raw;
         fix_lo = '1;
      end else begin
         fix_hi = ctl.neg_r ? -work_hi : work_hi;
         fix_lo = ctl.neg_q ? -work_lo : work_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl     <= '0;
         cnt     <= '0;
         opnd    <= '0;
         a_raw   <= '0;
         work_hi <= '0;
         work_lo <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         dz      <= 1'b0;
      end else begin
         done <= 1'b0;
         dz   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept_md) begin
                  ctl.is_div <= is_div_f;
                  ctl.neg_q  <= a_neg ^ b_neg;
                  ctl.neg_r  <= a_neg;
                  ctl.dz     <= is_div_f && (opb == '0);
                  cnt        <= '0;
                  opnd       <= is_div_f ? mag_b : mag_a;
                  work_lo    <= is_div_f ? mag_a : mag_b;
                  work_hi    <= '0;
                  a_raw      <= opa;
               end else if (accept_mt) begin
                  if (func == F_MTHI)
                     hi <= opa;
                  else
                     lo <= opa;
               end
            end
            S_RUN: begin
               cnt     <= cnt + 1'b1;
               work_hi <= hi_step;
               work_lo <= lo_step;
            end
            S_FIX: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               done <= 1'b1;
               dz   <= ctl.dz;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ee357_alu_muldiv.sv
// Directed bench for ee357_alu_muldiv at WIDTH=32: combinational ops, mul/div latency, HI/LO access, async abort.
module tb_ee357_alu_muldiv;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start;
   logic [5:0]  func;
   logic [31:0] opa, opb, res, hi, lo;
   logic        uov, sov, zero, cout, busy, done, dz;

   int total = 0;
   int bad   = 0;

   ee357_alu_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .opa(opa), .opb(opb),
      .res(res), .uov(uov), .sov(sov), .zero(zero), .cout(cout),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [3:0]  fl;   // {uov,sov,zero,cout}
   } vec_t;

   // Drive a start for exactly one rising edge; called at a falling edge.
   task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      func = f; opa = a; opb = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts falling edges with busy high; stops at the first one with busy low (bounded).
   task automatic wait_busy(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (dz !== 1'b0)   begin bad++; $display("FAIL reset_dz got=%b want=0", dz); end
      total++; if (hi !== 32'h0)  begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'h0)  begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_comb;
      vec_t tbl[15];
      tbl = '{
         '{F_ADD,  32'hffffffff, 32'h00000001, 32'h00000000, 4'b1011},
         '{F_ADD,  32'h7fffffff, 32'h00000001, 32'h80000000, 4'b0100},
         '{F_SUB,  32'h80000000, 32'h00000001, 32'h7fffffff, 4'b0101},
         '{F_SUB,  32'h00000000, 32'h00000001, 32'hffffffff, 4'b1000},
         '{F_SLL,  32'h0000001c, 32'h0000000a, 32'ha0000000, 4'b0000},
         '{F_SRA,  32'h0000001f, 32'h80000000, 32'hffffffff, 4'b0000},
         '{F_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 4'b0000},
         '{F_SLT,  32'hffffffff, 32'hfffffffe, 32'h00000000, 4'b0011},
         '{F_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 4'b0101},
         '{F_SLTU, 32'h00000001, 32'hffffffff, 32'h00000001, 4'b1000},
         '{F_AND,  32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 4'b0000},
         '{F_OR,   32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 4'b0000},
         '{F_XOR,  32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 4'b0000},
         '{F_NOR,  32'hf0f0f0f0, 32'hff00ff00, 32'h000f000f, 4'b0000},
         '{6'b111111, 32'h00000001, 32'h00000002, 32'h00000000, 4'b0010}
      };
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         func = tbl[i].f; opa = tbl[i].a; opb = tbl[i].b;
         #1;
         total++;
         if (res !== tbl[i].r) begin
            bad++; $display("FAIL comb_res[%0d] func=%b got=%h want=%h", i, tbl[i].f, res, tbl[i].r);
         end
         total++;
         if ({uov, sov, zero, cout} !== tbl[i].fl) begin
            bad++; $display("FAIL comb_flags[%0d] func=%b got=%b want=%b", i, tbl[i].f, {uov, sov, zero, cout}, tbl[i].fl);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mul;
      int n;
      launch(F_MULT, 32'hffffffff, 32'h00000002);
      wait_busy(n);
      total++; if (n != 33)          begin bad++; $display("FAIL mult_busy_cycles got=%0d want=33", n); end
      total++; if (done !== 1'b1)    begin bad++; $display("FAIL mult_done got=%b want=1", done); end
      total++; if (hi !== 32'hffffffff) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      total++; if (lo !== 32'hfffffffe) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", lo); end
      @(negedge clk);
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL mult_done_pulse got=%b want=0", done); end
      launch(F_MULTU, 32'hffffffff, 32'h00000002);
      wait_busy(n);
      total++; if (n != 33)          begin bad++; $display("FAIL multu_busy_cycles got=%0d want=33", n); end
      total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL multu_hi got=%h want=00000001", hi); end
      total++; if (lo !== 32'hfffffffe) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
      func = F_MFLO; #1;
      total++; if (res !== 32'hfffffffe) begin bad++; $display("FAIL mflo_res got=%h want=fffffffe", res); end
      @(negedge clk);
   endtask

   task automatic test_div;
      int n;
      launch(F_DIV, 32'hfffffff9, 32'h00000002);
      wait_busy(n);
      total++; if (done !== 1'b1)    begin bad++; $display("FAIL div_done got=%b want=1", done); end
      total++; if (dz !== 1'b0)      begin bad++; $display("FAIL div_dz got=%b want=0", dz); end
      total++; if (lo !== 32'hfffffffd) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      total++; if (hi !== 32'hffffffff) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
      @(negedge clk);
      launch(F_DIVU, 32'h00000007, 32'h00000000);
      wait_busy(n);
      total++; if (n != 33)          begin bad++; $display("FAIL divz_busy_cycles got=%0d want=33", n); end
      total++; if (dz !== 1'b1)      begin bad++; $display("FAIL divz_dz got=%b want=1", dz); end
      total++; if (hi !== 32'h00000007) begin bad++; $display("FAIL divz_hi got=%h want=00000007", hi); end
      total++; if (lo !== 32'hffffffff) begin bad++; $display("FAIL divz_lo got=%h want=ffffffff", lo); end
      @(negedge clk);
      total++; if (dz !== 1'b0)      begin bad++; $display("FAIL divz_dz_clear got=%b want=0", dz); end
      launch(F_DIV, 32'h80000000, 32'hffffffff);
      wait_busy(n);
      total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divmin_lo got=%h want=80000000", lo); end
      total++; if (hi !== 32'h00000000) begin bad++; $display("FAIL divmin_hi got=%h want=00000000", hi); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      int first;
      launch(F_MTHI, 32'h12345678, 32'h0);
      total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi got=%h want=12345678", hi); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_no_busy got=%b%b want=00", busy, done); end
      launch(F_MULTU, 32'h00000003, 32'h00000005);
      @(negedge clk);
      first = busy ? 1 : 0;
      launch(F_DIVU, 32'h00000064, 32'h00000007);
      func = F_MFHI; #1;
      total++; if (res !== 32'h12345678) begin bad++; $display("FAIL mfhi_busy got=%h want=12345678", res); end
      wait_busy(n);
      total++; if (first + n != 33) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=33", first + n); end
      total++; if (hi !== 32'h0)     begin bad++; $display("FAIL b2b_hi got=%h want=00000000", hi); end
      total++; if (lo !== 32'h0000000f) begin bad++; $display("FAIL b2b_lo got=%h want=0000000f", lo); end
      // new start in the done cycle must be taken
      total++; if (done !== 1'b1)    begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
      launch(F_DIVU, 32'h00000064, 32'h00000007);
      wait_busy(n);
      total++; if (n != 33)          begin bad++; $display("FAIL chain_busy_cycles got=%0d want=33", n); end
      total++; if (lo !== 32'h0000000e) begin bad++; $display("FAIL chain_lo got=%h want=0000000e", lo); end
      total++; if (hi !== 32'h00000002) begin bad++; $display("FAIL chain_hi got=%h want=00000002", hi); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int n;
      launch(F_MULT, 32'h00000005, 32'h00000007);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL abort_done got=%b want=0", done); end
      total++; if (hi !== 32'h0)     begin bad++; $display("FAIL abort_hi got=%h want=0", hi); end
      total++; if (lo !== 32'h0)     begin bad++; $display("FAIL abort_lo got=%h want=0", lo); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      launch(F_MULTU, 32'h00000002, 32'h00000003);
      wait_busy(n);
      total++; if (n != 33)          begin bad++; $display("FAIL post_abort_cycles got=%0d want=33", n); end
      total++; if (lo !== 32'h00000006) begin bad++; $display("FAIL post_abort_lo got=%h want=00000006", lo); end
      total++; if (hi !== 32'h0)     begin bad++; $display("FAIL post_abort_hi got=%h want=0", hi); end
   endtask

   initial begin
      start = 1'b0; func = 6'b0; opa = 32'h0; opb = 32'h0;
      test_reset;
      test_comb;
      test_mul;
      test_div;
      test_back_to_back;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ee357_alu_muldiv.md
# ee357_alu_muldiv

Parametrised successor to the `ee357_alu` datapath for the multicycle CPU. It keeps the single-cycle combinational ALU ops, with identical func codes and flag semantics, for any `WIDTH`. It adds an iterative multiply/divide engine that writes HI/LO registers, with MTHI/MTLO/MFHI/MFLO access. It sits in the execute stage; the control FSM stalls on `busy` and advances on `done`.

## Interface
- `WIDTH`, 32: datapath width; power of two, 8 to 64. The shift-amount width `SW` = $clog2(WIDTH).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launches MULT/MULTU/DIV/DIVU/MTHI/MTLO when sampled high.
- `func` in 6: operation select.
- `opa` in WIDTH: operand A; for shifts, `opa[SW-1:0]` is the shift amount.
- `opb` in WIDTH: operand B; for shifts, the value being shifted.
- `res` out WIDTH: combinational result.
- `uov` out 1: unsigned overflow/borrow.
- `sov` out 1: signed overflow.
- `zero` out 1: `res` is all zeros.
- `cout` out 1: adder carry-out.
- `busy` out 1: mul/div engine active.
- `done` out 1: one-cycle pulse when HI/LO are updated.
- `dz` out 1: divide-by-zero, valid with `done`.
- `hi`, `lo` out WIDTH: HI/LO register contents.

## Operation
- Combinational ops (`res` and flags are a pure function of `func`/`opa`/`opb`/HI/LO):
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010.
  - SLTU 101011 is new.
  - SLL 000000, SRL 000010, SRA 000011.
  - MFHI 010000 gives `res`=hi; MFLO 010010 gives `res`=lo.
  - Any other func gives `res`=0.
- Flag rules:
  - ADD: `cout` = carry out of opa+opb; `uov` = `cout`.
  - SUB, SLT, SLTU: computed as opa+~opb+1; `cout` = that carry; `uov` = ~`cout`.
  - `sov`: two's-complement overflow of that add/sub.
  - SLT `res` = signed less-than. SLTU `res` = ~`cout`.
  - `uov`/`sov`/`cout` are 0 for all non-add/sub ops.
  - `zero` = (`res`==0) for every func.
- Sequential funcs, only acted on when `start` is high and `busy` is low:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MTHI 010001 and MTLO 010011: write `opa` into hi/lo in one edge; no `busy`, no `done`.
  - `start` with any other func, or while `busy`, is ignored.
- Multiply: radix-2 shift-add on operand magnitudes, WIDTH iterations. The 2·WIDTH product goes to {hi,lo}, negated at fix-up when operand signs differ (signed only).
- Divide: restoring division on magnitudes, WIDTH iterations; lo = quotient, hi = remainder.
  - Signed: quotient is negated if signs differ; remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives lo = 100…0, hi = 0.
- Divide by zero (opb==0): `dz`=1 with `done`; hi = opa, lo = all ones. Latency is unchanged.
- FSM states:
  - IDLE → RUN on an accepted mul/div start; operands are captured and the counter cleared.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE: sign correction, HI/LO write, `done`=1.

## Timing
- Reset (async) values: `busy`=0, `done`=0, `dz`=0, hi=0, lo=0, FSM=IDLE, counter=0. Reset mid-operation aborts immediately with no HI/LO write.
- Mul/div latency, with start sampled at edge 0:
  - `busy`=1 from after edge 0 until edge WIDTH+1, i.e. WIDTH+1 cycles.
  - `done`=1 (and `dz` if applicable) for exactly the cycle after edge WIDTH+1.
  - hi/lo hold their old values until edge WIDTH+1; MFHI/MFLO during `busy` return the old values.
  - A new `start` is accepted in the same cycle that `done` is high.
- Combinational ops have zero latency and are unaffected by `busy`.
- `dz` clears on the cycle after `done`.

## Test plan
- ADD ffffffff+00000001 → `res`=00000000, {uov,sov,zero,cout}=1011.
  - ADD 7fffffff+1 → 80000000, flags 0100.
  - SUB 80000000−1 → 7fffffff, flags 0101.
  - SUB 0−1 → ffffffff, flags 1000.
- SLL opa=1c, opb=0000000a → a0000000. SRA opa=1f, opb=80000000 → ffffffff.
  - SLT ffffffff,fffffffe → 0, flags 0011.
  - SLTU 00000001,ffffffff → 1, flags 1000.
- MULT ffffffff×00000002 → `busy` 33 cycles, `done` 1 cycle, hi=ffffffff, lo=fffffffe.
  - MULTU with the same operands → hi=00000001, lo=fffffffe.
- DIV fffffff9÷00000002 → lo=fffffffd, hi=ffffffff.
  - DIVU 00000007÷0 → `dz`=1, hi=00000007, lo=ffffffff.
  - DIV 80000000÷ffffffff → lo=80000000, hi=0.
- Preload MTHI 12345678; start MULTU 3×5. During `busy`:
  - a second `start` (DIVU) is ignored;
  - MFHI gives `res`=12345678;
  - after `done`: hi=0, lo=0000000f.
- Assert `rst` asynchronously 10 cycles into a MULT → `busy`/`done`/hi/lo all 0 immediately. A following MULTU 2×3 completes with lo=6 after 33 cycles.
